ifetch_queue: RTL and testbench

- Instruction-fetch front end that drives the instruction ROM's word-addressed fetch port and buffers returned instructions for decode.
- Holds the fetch PC and captures the ROM's same-cycle combinational instruction, together with its PC, into a small FIFO.
- Presents the FIFO head to decode with a valid/ready handshake.
- Handles branch/jump redirects (flush) and out-of-range fetch (halt with fault flag).

---
 rtl/ifetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/ifetch_queue.sv | 114 +++++++++++
 tb/tb_ifetch_queue.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and default parameters for the instruction-fetch front end.
package ifetch_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] ROM_BYTES_DEF = 32'd65536;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, inst} entries with flush; the head
// output holds its last shown value while the queue is empty.
module fetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fq_entry_t        din,
  output fq_entry_t        head,
  output logic [CNT_W-1:0] count
);

  fq_entry_t        mem [DEPTH];
  fq_entry_t        last;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             empty;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full queue still accepts a push when its head leaves on the same edge.
  assign do_push = push & (~full | do_pop);

  assign head = empty ? last : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      last   <= '0;
    end else begin
      last <= head;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        if (do_push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: drives the ROM fetch port, queues returned
// instructions for decode, and handles redirects and out-of-range halts.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] ROM_BYTES = ROM_BYTES_DEF,
  parameter int          DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  input  logic        out_ready,
  output logic        fetch_fault
);

  localparam int          CNT_W    = $clog2(DEPTH) + 1;
  localparam logic [31:0] BOOT_PC  = RESET_PC & 32'hFFFF_FFFC;

  fetch_state_t     state;
  fetch_state_t     state_next;
  logic [31:0]      fetch_pc;
  logic [31:0]      fetch_pc_next;
  logic [31:0]      pc_plus4;
  logic             fault_next;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] count;
  fq_entry_t        head;
  fq_entry_t        din;

  assign imem_addr = fetch_pc;
  assign pc_plus4  = fetch_pc + 32'd4;
  assign out_valid = (count != '0);
  assign out_pc    = head.pc;
  assign out_inst  = head.inst;
  assign pop       = out_valid & out_ready;
  assign din       = '{pc: fetch_pc, inst: imem_inst};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      fetch_pc    <= BOOT_PC;
      fetch_fault <= 1'b0;
    end else begin
      state       <= state_next;
      fetch_pc    <= fetch_pc_next;
      fetch_fault <= fault_next;
    end
  end

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    fault_next    = fetch_fault;
    push          = 1'b0;
    if (redirect_valid) begin
      state_next    = RUN;
      fetch_pc_next = redirect_pc & 32'hFFFF_FFFC;
      fault_next    = 1'b0;
    end else begin
      unique case (state)
        BOOT: begin
          if (fetch_pc >= ROM_BYTES) begin
            state_next = HALT;
            fault_next = 1'b1;
          end else begin
            state_next = RUN;
          end
        end
        RUN: begin
          if (fetch_pc >= ROM_BYTES) begin
            state_next = HALT;
            fault_next = 1'b1;
          end else if ((count != CNT_W'(DEPTH)) || pop) begin
            push          = 1'b1;
            fetch_pc_next = pc_plus4;
            // Stop as soon as the next fetch would leave the ROM.
            if (pc_plus4 >= ROM_BYTES) begin
              state_next = HALT;
              fault_next = 1'b1;
            end
          end
        end
        HALT: begin
          state_next = HALT;
        end
        default: begin
          state_next = HALT;
        end
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .flush(redirect_valid),
    .din  (din),
    .head (head),
    .count(count)
  );

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: a queue-based reference model tracks the expected
// head, fault and fetch address for a full-size and a tiny-ROM instance.
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_ready = 1'b0;
  logic        sel = 1'b0;
  logic [31:0] salt = '0;

  logic [31:0] addr0, inst0, pc0, oinst0;
  logic [31:0] addr1, inst1, pc1, oinst1;
  logic        valid0, fault0, valid1, fault1;

  logic [31:0] addr_s, pc_s, inst_s;
  logic        valid_s, fault_s;

  int tests_run = 0;
  int fails = 0;

  logic [63:0] m_q[$];
  logic [63:0] m_disp;
  logic [31:0] m_pc;
  bit          m_boot, m_halt, m_fault;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a >> 2) ^ salt;
  endfunction

  assign inst0 = rom_word(addr0);
  assign inst1 = rom_word(addr1);

  assign addr_s  = sel ? addr1  : addr0;
  assign pc_s    = sel ? pc1    : pc0;
  assign inst_s  = sel ? oinst1 : oinst0;
  assign valid_s = sel ? valid1 : valid0;
  assign fault_s = sel ? fault1 : fault0;

  ifetch_queue dut (
    .clk(clk), .rst(rst), .imem_addr(addr0), .imem_inst(inst0),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(valid0), .out_pc(pc0), .out_inst(oinst0),
    .out_ready(out_ready), .fetch_fault(fault0)
  );

  ifetch_queue #(.ROM_BYTES(32'h20)) dut_small (
    .clk(clk), .rst(rst), .imem_addr(addr1), .imem_inst(inst1),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(valid1), .out_pc(pc1), .out_inst(oinst1),
    .out_ready(out_ready), .fetch_fault(fault1)
  );

  function automatic void model_reset();
    m_q.delete();
    m_disp  = '0;
    m_pc    = 32'h0;
    m_boot  = 1'b1;
    m_halt  = 1'b0;
    m_fault = 1'b0;
  endfunction

  function automatic void model_edge();
    logic [31:0] rom = sel ? 32'h20 : 32'h10000;
    bit          pop = (m_q.size() != 0) && out_ready;
    int          sz  = m_q.size();
    if (redirect_valid) begin
      m_q.delete();
      m_pc    = redirect_pc & 32'hFFFF_FFFC;
      m_fault = 1'b0;
      m_halt  = 1'b0;
      m_boot  = 1'b0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (m_boot) begin
        m_boot = 1'b0;
        if (m_pc >= rom) begin m_halt = 1'b1; m_fault = 1'b1; end
      end else if (!m_halt) begin
        if (m_pc >= rom) begin
          m_halt = 1'b1; m_fault = 1'b1;
        end else if (sz < 4 || pop) begin
          m_q.push_back({m_pc, rom_word(m_pc)});
          m_pc = m_pc + 32'd4;
          if (m_pc >= rom) begin m_halt = 1'b1; m_fault = 1'b1; end
        end
      end
    end
    if (m_q.size() != 0) m_disp = m_q[0];
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    redirect_valid = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    tests_run++;
    if (valid0 !== 1'b0 || valid1 !== 1'b0) begin
      fails++; $display("FAIL reset_valid got %b%b want 00", valid0, valid1);
    end
    tests_run++;
    if (pc0 !== 32'h0 || oinst0 !== 32'h0) begin
      fails++; $display("FAIL reset_head got pc=%h inst=%h want 0/0", pc0, oinst0);
    end
    tests_run++;
    if (fault0 !== 1'b0 || fault1 !== 1'b0) begin
      fails++; $display("FAIL reset_fault got %b%b want 00", fault0, fault1);
    end
    tests_run++;
    if (addr0 !== 32'h0) begin
      fails++; $display("FAIL reset_addr got %h want 0", addr0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    step();
    tests_run++;
    if (valid0 !== 1'b0) begin
      fails++; $display("FAIL boot_valid got %b want 0", valid0);
    end
    for (int k = 0; k < 8; k++) begin
      step();
      tests_run++;
      if (valid0 !== 1'b1 || pc0 !== 32'(4 * k) || oinst0 !== 32'(k)) begin
        fails++;
        $display("FAIL stream_head[%0d] got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                 k, valid0, pc0, oinst0, 32'(4 * k), 32'(k));
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) step();
    tests_run++;
    if (addr0 !== 32'h10 || valid0 !== 1'b1 || pc0 !== 32'h0) begin
      fails++; $display("FAIL full_hold got addr=%h v=%b pc=%h want addr=10 v=1 pc=0",
                        addr0, valid0, pc0);
    end
    out_ready = 1'b1;
    step();
    tests_run++;
    if (addr0 !== 32'h14) begin
      fails++; $display("FAIL full_pop_push got addr=%h want 14", addr0);
    end
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) step();
      tests_run++;
      if (valid0 !== 1'b1 || pc0 !== 32'(4 * k) || oinst0 !== 32'(k)) begin
        fails++; $display("FAIL drain_head[%0d] got v=%b pc=%h want v=1 pc=%h",
                          k, valid0, pc0, 32'(4 * k));
      end
    end
  endtask

  task automatic test_redirect_full();
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) step();
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h103;
    step();
    redirect_valid = 1'b0;
    tests_run++;
    if (valid0 !== 1'b0) begin
      fails++; $display("FAIL redirect_flush got v=%b want 0", valid0);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      tests_run++;
      if (valid0 !== 1'b1 || pc0 !== 32'h100 + 32'(4 * k) || oinst0 !== 32'h40 + 32'(k)) begin
        fails++; $display("FAIL redirect_head[%0d] got v=%b pc=%h inst=%h want pc=%h inst=%h",
                          k, valid0, pc0, oinst0, 32'h100 + 32'(4 * k), 32'h40 + 32'(k));
      end
    end
  endtask

  task automatic test_fault();
    logic [31:0] last_pc = '0;
    sel = 1'b1;
    apply_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      step();
      if (valid1) last_pc = pc1;
    end
    tests_run++;
    if (last_pc !== 32'h1C) begin
      fails++; $display("FAIL fault_last_pc got %h want 1c", last_pc);
    end
    tests_run++;
    if (fault1 !== 1'b1 || valid1 !== 1'b0 || addr1 !== 32'h20) begin
      fails++; $display("FAIL fault_halt got f=%b v=%b addr=%h want f=1 v=0 addr=20",
                        fault1, valid1, addr1);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    step();
    redirect_valid = 1'b0;
    tests_run++;
    if (fault1 !== 1'b0) begin
      fails++; $display("FAIL fault_clear got %b want 0", fault1);
    end
    step();
    tests_run++;
    if (valid1 !== 1'b1 || pc1 !== 32'h0) begin
      fails++; $display("FAIL fault_resume got v=%b pc=%h want v=1 pc=0", valid1, pc1);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    tests_run++;
    if (fault1 !== 1'b0 || valid1 !== 1'b0) begin
      fails++; $display("FAIL oor_redirect got f=%b v=%b want f=0 v=0", fault1, valid1);
    end
    step();
    tests_run++;
    if (fault1 !== 1'b1 || valid1 !== 1'b0 || addr1 !== 32'h40) begin
      fails++; $display("FAIL oor_halt got f=%b v=%b addr=%h want f=1 v=0 addr=40",
                        fault1, valid1, addr1);
    end
    sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    step();
    redirect_pc = 32'h80;
    step();
    redirect_valid = 1'b0;
    tests_run++;
    if (valid0 !== 1'b0 || addr0 !== 32'h80) begin
      fails++; $display("FAIL b2b_flush got v=%b addr=%h want v=0 addr=80", valid0, addr0);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      tests_run++;
      if (valid0 !== 1'b1 || pc0 !== 32'h80 + 32'(4 * k)) begin
        fails++; $display("FAIL b2b_head[%0d] got v=%b pc=%h want pc=%h",
                          k, valid0, pc0, 32'h80 + 32'(4 * k));
      end
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) step();
    tests_run++;
    if (valid0 !== 1'b1 || pc0 !== 32'h0 || addr0 !== 32'hC) begin
      fails++; $display("FAIL pre_reset got v=%b pc=%h addr=%h want v=1 pc=0 addr=c",
                        valid0, pc0, addr0);
    end
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    tests_run++;
    if (valid0 !== 1'b0 || addr0 !== 32'h0 || pc0 !== 32'h0 || fault0 !== 1'b0) begin
      fails++; $display("FAIL async_reset got v=%b addr=%h pc=%h f=%b want 0/0/0/0",
                        valid0, addr0, pc0, fault0);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    tests_run++;
    if (valid0 !== 1'b1 || pc0 !== 32'h0 || oinst0 !== 32'h0) begin
      fails++; $display("FAIL restart_head got v=%b pc=%h inst=%h want v=1 pc=0 inst=0",
                        valid0, pc0, oinst0);
    end
    step();
    tests_run++;
    if (pc0 !== 32'h4) begin
      fails++; $display("FAIL restart_next got pc=%h want 4", pc0);
    end
  endtask

  task automatic test_random();
    for (int phase = 0; phase < 2; phase++) begin
      sel = phase[0];
      salt = $urandom;
      apply_reset();
      for (int k = 0; k < 300; k++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        redirect_valid = ($urandom_range(0, 19) == 0);
        redirect_pc = sel ? 32'($urandom_range(0, 48)) : 32'($urandom_range(0, 70000));
        step();
        tests_run++;
        if (valid_s !== (m_q.size() != 0) || {pc_s, inst_s} !== m_disp ||
            fault_s !== m_fault || addr_s !== m_pc) begin
          fails++;
          $display("FAIL random[%0d.%0d] got v=%b pc=%h inst=%h f=%b addr=%h want v=%b pc=%h inst=%h f=%b addr=%h",
                   phase, k, valid_s, pc_s, inst_s, fault_s, addr_s,
                   (m_q.size() != 0), m_disp[63:32], m_disp[31:0], m_fault, m_pc);
        end
      end
    end
    redirect_valid = 1'b0;
    sel = 1'b0;
    salt = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_fault();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
